bios_dump: RTL and testbench

Memory readback transmitter: the counterpart to the boot loader that fills instruction memory from a serial stream. On a start pulse it reads a block of consecutive words from instruction memory over the shared memory port and sends each word out on a serial line as a framed bit stream. It sits beside `memory` in `main`, owns the memory port while `busy` is high, and is used for post-boot verification and debug dumps.

---
 rtl/bios_dump_pkg.sv | 30 +++
 rtl/bios_dump_if.sv | 27 ++
 rtl/bios_dump_bit_timer.sv | 43 ++++
 rtl/bios_dump.sv | 158 +++++++++++++++
 tb/tb_bios_dump.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bios_dump_pkg.sv
// Shared definitions for the memory readback transmitter and its bit timer.
package bios_dump_pkg;

    // One frame is a start bit, a 32-bit word sent LSB first, and a stop bit.
    localparam int FRAME_BITS = 34;
    localparam int WORD_BITS  = 32;

    // Wide enough to count every bit position of a frame (0..FRAME_BITS).
    localparam int INDEX_W = 6;

    // Bit index of the last data bit: index 0 is the start bit, 1..32 are data.
    localparam logic [INDEX_W-1:0] LAST_DATA_INDEX = INDEX_W'(WORD_BITS);

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } dumpState_t;

    // Word address of the next fetch; wraps from the top of the space to zero.
    function automatic logic [31:0] nextAddress(input logic [31:0] current);
        return current + 32'd1;
    endfunction

endpackage

// File: rtl/bios_dump_if.sv
// Instruction-memory port shared between the boot path and the readback dump.
interface bios_dump_if;

    logic [31:0] Address;   // word address
    logic        CS;        // chip select, active-low
    logic        OE;        // output enable, active-high
    logic        WE;        // write enable, active-high
    logic [31:0] DataOut;   // read data from memory

    // The requester drives the address and strobes; memory returns read data.
    modport master (
        output Address,
        output CS,
        output OE,
        output WE,
        input  DataOut
    );

    modport slave (
        input  Address,
        input  CS,
        input  OE,
        input  WE,
        output DataOut
    );

endinterface

// File: rtl/bios_dump_bit_timer.sv
// Serial bit timer: a CLKS_PER_BIT down-counter plus a bit index. bitTick is
// high during the last cycle of each bit; bitIndex advances on that tick.
// Shared with the serial receiver on the boot path.
module bit_timer
    import bios_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clock,
    input  logic               reset,      // asynchronous, active-low
    input  logic               clear,      // restart at bit 0 with a full count
    input  logic               enable,     // count while high
    output logic               bitTick,
    output logic [INDEX_W-1:0] bitIndex
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Last cycle of the current bit is the one where the counter sits at zero.
    assign bitTick = enable && (count == '0);

    // Count down within a bit; reload and advance the index at bit boundaries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            bitIndex <= '0;
        end else if (clear) begin
            count    <= RELOAD;
            bitIndex <= '0;
        end else if (enable) begin
            if (count == '0) begin
                count    <= RELOAD;
                bitIndex <= bitIndex + 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bios_dump.sv
// Memory readback transmitter. On an accepted start it reads word_count
// consecutive words from instruction memory, starting at base_address, and
// sends each one on tx as a start bit, 32 data bits LSB first, and a stop bit.
// The memory port is owned by this block only while busy is high.
//
// Request handshake: start is a single-cycle request with no ready return; it
// is accepted only on a rising edge where the FSM is in IDLE (busy low and not
// in the done cycle), and base_address/word_count are captured on that same
// edge. Requests seen at any other time are dropped.
module bios_dump
    import bios_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clock,
    input  logic               reset,          // asynchronous, active-low
    input  logic               start,
    input  logic [31:0]        base_address,
    input  logic [15:0]        word_count,
    bios_dump_if.master        memPort,
    output logic               tx,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] stateDebug
);

    localparam logic [STATE_W-1:0] stateIdle  = IDLE;
    localparam logic [STATE_W-1:0] stateFetch = FETCH;
    localparam logic [STATE_W-1:0] stateStart = START;
    localparam logic [STATE_W-1:0] stateData  = DATA;
    localparam logic [STATE_W-1:0] stateStop  = STOP;
    localparam logic [STATE_W-1:0] stateDone  = DONE;

    logic [STATE_W-1:0]   state;
    logic [31:0]          addressReg;
    logic                 csReg;
    logic                 oeReg;
    logic [WORD_BITS-1:0] shiftReg;
    logic [15:0]          remaining;

    logic                 timerClear;
    logic                 timerEnable;
    logic                 bitTick;
    logic [INDEX_W-1:0]   bitIndex;

    assign memPort.Address = addressReg;
    assign memPort.CS      = csReg;
    assign memPort.OE      = oeReg;
    assign memPort.WE      = 1'b0;    // readback never writes

    assign stateDebug = state;

    // The timer restarts in the fetch cycle so the start bit begins at a full count.
    assign timerClear  = (state == stateFetch);
    assign timerEnable = (state == stateStart) || (state == stateData) ||
                         (state == stateStop);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bitTimer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timerClear),
        .enable   (timerEnable),
        .bitTick  (bitTick),
        .bitIndex (bitIndex)
    );

    // Dump sequencer: fetch a word, serialise its frame, repeat until the count runs out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= stateIdle;
            addressReg <= '0;
            csReg      <= 1'b1;
            oeReg      <= 1'b0;
            shiftReg   <= '0;
            remaining  <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                stateIdle: begin
                    if (start) begin
                        if (word_count != 16'd0) begin
                            state      <= stateFetch;
                            busy       <= 1'b1;
                            addressReg <= base_address;
                            csReg      <= 1'b0;
                            oeReg      <= 1'b1;
                            remaining  <= word_count;
                        end else begin
                            // Empty request: report completion without touching memory.
                            state <= stateDone;
                            done  <= 1'b1;
                        end
                    end
                end

                stateFetch: begin
                    // Read data is captured as the port is released; the start bit begins now.
                    shiftReg <= memPort.DataOut;
                    csReg    <= 1'b1;
                    oeReg    <= 1'b0;
                    tx       <= 1'b0;
                    state    <= stateStart;
                end

                stateStart: begin
                    if (bitTick) begin
                        tx       <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        state    <= stateData;
                    end
                end

                stateData: begin
                    if (bitTick) begin
                        if (bitIndex == LAST_DATA_INDEX) begin
                            tx    <= 1'b1;
                            state <= stateStop;
                        end else begin
                            tx       <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                        end
                    end
                end

                stateStop: begin
                    if (bitTick) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= stateDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // The fetch cycle doubles as the single idle-high gap between frames.
                            state      <= stateFetch;
                            addressReg <= nextAddress(addressReg);
                            csReg      <= 1'b0;
                            oeReg      <= 1'b1;
                        end
                    end
                end

                stateDone: begin
                    state <= stateIdle;
                end

                default: begin
                    state <= stateIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bios_dump.sv
// Self-checking bench for bios_dump: directed dumps with a scoreboard that
// decodes the serial stream, watches memory fetches and the done pulse.
module tb_bios_dump;

    localparam int CPB      = 4;
    localparam int WORD_CYC = 137;          // 1 fetch cycle + 34 bits * 4 cycles
    localparam int FRAME_CYC = 136;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] base_address;
    logic [15:0] word_count;
    logic        tx;
    logic        busy;
    logic        done;
    logic [2:0]  stateDebug;

    bios_dump_if memBus ();

    bios_dump #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_address (base_address),
        .word_count   (word_count),
        .memPort      (memBus.master),
        .tx           (tx),
        .busy         (busy),
        .done         (done),
        .stateDebug   (stateDebug)
    );

    // Memory model: read data is presented while the port is selected and enabled.
    logic [31:0] mem [0:255];
    assign memBus.DataOut = (!memBus.CS && memBus.OE) ? mem[memBus.Address[7:0]] : 32'hDEAD_BEEF;

    // Clock and cycle counter
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard
    int tests = 0;
    int fails = 0;

    logic [31:0] expWordQ  [$];
    logic [31:0] expAddrQ  [$];
    logic [31:0] expFetchQ [$];
    logic [31:0] expFrameQ [$];
    logic [31:0] expDoneQ  [$];

    int doneSeen = 0;
    int doneMark = 0;
    int startCyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Fetch monitor: every selected cycle must match the next expected address and cycle.
    always @(negedge clock) begin
        if (reset && !memBus.CS) begin
            if (expAddrQ.size() == 0) begin
                unexpected("fetch");
            end else begin
                check("fetch address", memBus.Address, expAddrQ.pop_front());
                check("fetch cycle", 32'(cyc), expFetchQ.pop_front());
                check("fetch OE", {31'd0, memBus.OE}, 32'd1);
                check("fetch WE", {31'd0, memBus.WE}, 32'd0);
            end
        end
    end

    // Done monitor
    always @(negedge clock) begin
        if (reset && done) begin
            doneSeen++;
            check("busy during done", {31'd0, busy}, 32'd0);
            if (expDoneQ.size() == 0) unexpected("done");
            else check("done cycle", 32'(cyc), expDoneQ.pop_front());
        end
    end

    // Serial decoder: sample every cycle of a frame, verify hold, stop bit and word.
    logic        rxActive = 1'b0;
    int          rxCnt;
    int          rxStart;
    logic        rxGlitch;
    logic [33:0] rxFrame;

    always @(negedge clock) begin
        if (!reset) begin
            rxActive = 1'b0;
        end else begin
            if (!rxActive && tx == 1'b0) begin
                rxActive = 1'b1;
                rxCnt    = 0;
                rxStart  = cyc;
                rxGlitch = 1'b0;
                rxFrame  = '0;
            end
            if (rxActive) begin
                if (rxCnt % CPB == 0) rxFrame[rxCnt / CPB] = tx;
                else if (tx !== rxFrame[rxCnt / CPB]) rxGlitch = 1'b1;
                rxCnt++;
                if (rxCnt == FRAME_CYC) begin
                    rxActive = 1'b0;
                    if (expWordQ.size() == 0) begin
                        unexpected("frame");
                    end else begin
                        check("frame bit hold", {31'd0, rxGlitch}, 32'd0);
                        check("stop bit", {31'd0, rxFrame[33]}, 32'd1);
                        check("frame word", rxFrame[32:1], expWordQ.pop_front());
                        check("frame start cycle", 32'(rxStart), expFrameQ.pop_front());
                    end
                end
            end
        end
    end

    // Driver: request a dump and queue every response it should produce.
    task automatic issueDump(input logic [31:0] base, input logic [15:0] count);
        logic [31:0] a;
        @(negedge clock);
        base_address = base;
        word_count   = count;
        start        = 1'b1;
        startCyc     = cyc + 1;
        doneMark     = doneSeen;
        for (int i = 0; i < int'(count); i++) begin
            a = base + 32'(i);
            expAddrQ.push_back(a);
            expWordQ.push_back(mem[a[7:0]]);
            expFetchQ.push_back(32'(startCyc + i * WORD_CYC));
            expFrameQ.push_back(32'(startCyc + 1 + i * WORD_CYC));
        end
        expDoneQ.push_back(32'(startCyc + int'(count) * WORD_CYC));
        @(negedge clock);
        start = 1'b0;
        check("busy after accept", {31'd0, busy}, {31'd0, count != 16'd0});
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (doneSeen == doneMark && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (doneSeen == doneMark) unexpected("done timeout");
        repeat (4) @(negedge clock);
        check("word queue drained", 32'(expWordQ.size()), 32'd0);
        check("addr queue drained", 32'(expAddrQ.size()), 32'd0);
        check("done queue drained", 32'(expDoneQ.size()), 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, " tx"},   {31'd0, tx}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " CS"},   {31'd0, memBus.CS}, 32'd1);
        check({tag, " OE"},   {31'd0, memBus.OE}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        base_address = 32'h0;
        word_count   = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        mem[8'h10] = 32'hA5A5_0F0F;
        mem[8'h20] = 32'h0000_0001;
        mem[8'h21] = 32'h0000_0002;
        mem[8'h22] = 32'h0000_0003;
        mem[8'hFF] = 32'h1234_5678;
        mem[8'h00] = 32'hCAFE_F00D;
        mem[8'h30] = 32'h0F0F_00FF;
        mem[8'h40] = 32'h1111_1111;
        mem[8'h50] = 32'h8000_0001;
        mem[8'h51] = 32'hFFFF_0000;

        // Reset state
        repeat (3) @(negedge clock);
        checkIdleOutputs("reset");
        check("reset Address", memBus.Address, 32'h0);
        check("reset WE", {31'd0, memBus.WE}, 32'd0);
        check("reset state", {29'd0, stateDebug}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single word
        issueDump(32'h10, 16'd1);
        waitDone(WORD_CYC + 20);

        // Three consecutive words
        issueDump(32'h20, 16'd3);
        waitDone(3 * WORD_CYC + 20);

        // Zero count: only a done pulse, no memory or line activity
        issueDump(32'h60, 16'd0);
        for (int i = 0; i < 3; i++) begin
            check("zero busy", {31'd0, busy}, 32'd0);
            check("zero CS", {31'd0, memBus.CS}, 32'd1);
            check("zero tx", {31'd0, tx}, 32'd1);
            @(negedge clock);
        end
        waitDone(20);

        // Address wrap
        issueDump(32'hFFFF_FFFF, 16'd2);
        waitDone(2 * WORD_CYC + 20);

        // Start re-pulsed mid-frame with different inputs is ignored
        issueDump(32'h30, 16'd1);
        repeat (18) @(negedge clock);
        base_address = 32'h40;
        word_count   = 16'd3;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(WORD_CYC + 20);
        repeat (20) @(negedge clock);

        // Reset in the middle of a data bit
        issueDump(32'h50, 16'd2);
        repeat (60) @(negedge clock);
        #2;
        reset = 1'b0;
        expWordQ.delete();
        expAddrQ.delete();
        expFetchQ.delete();
        expFrameQ.delete();
        expDoneQ.delete();
        #1;
        checkIdleOutputs("async reset");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        issueDump(32'h50, 16'd1);
        waitDone(WORD_CYC + 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
